// File: rtl/fifo_stream_reader.sv
// Pops a 1-cycle-latency FIFO into a 2-entry buffer and streams it valid/ready at 1 word/clk, M_LAST every PKT_LEN beats.
// Define FIFO_RD_STATS_EN to add saturating word_cnt / stall_cnt statistics outputs.
module fifo_stream_reader #(
  parameter int DW      = 16,
  parameter int PKT_LEN = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          fifo_rd,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
`ifdef FIFO_RD_STATS_EN
  output logic [31:0]   word_cnt,
  output logic [31:0]   stall_cnt,
`endif
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

  state_t        state;
  logic [1:0]    occ;
  logic          inflight;
  logic [DW-1:0] buf_head;
  logic [DW-1:0] buf_tail;
  logic [7:0]    beat_cnt;
  logic          pop;
  logic [2:0]    pending;

  assign pop     = m_valid & m_ready;
  assign pending = {1'b0, occ} + {2'b00, inflight};
  // A slot freed by this cycle's pop can already be claimed by a new read.
  assign fifo_rd = (state == RUN) & ~fifo_empty & (pending < (3'd2 + {2'b00, pop}));
  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_head;
  assign m_last  = m_valid & (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) state <= DRAIN;
        end
        DRAIN: begin
          if (en) begin
            state <= RUN;
          end else if (!inflight && occ == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      inflight <= fifo_rd;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf_head <= fifo_dout;
          else             buf_tail <= fifo_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf_head <= fifo_dout;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // Packet position survives EN toggling; only reset restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= 8'd0;
    end else if (pop) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? 8'd0 : beat_cnt + 8'd1;
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (pop && word_cnt != 32'hFFFF_FFFF)
        word_cnt <= word_cnt + 32'd1;
      if (m_valid && !m_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural 1-cycle-latency FIFO (PKT_LEN=4).
module tb_fifo_stream_reader;

  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        fifo_rd;
  logic [15:0] fifo_dout;
  logic        fifo_empty;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
`ifdef FIFO_RD_STATS_EN
  logic [31:0] word_cnt;
  logic [31:0] stall_cnt;
`endif

  fifo_stream_reader #(.DW(16), .PKT_LEN(PL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
`ifdef FIFO_RD_STATS_EN
    .word_cnt   (word_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [15:0] fifo_q[$];
  logic [16:0] sb[$];
  int          tb_beats = 0;
  int          cyc = 0;
  logic        rd_s = 1'b0;

  int rd_cnt, first_rd, first_vld, pop_cnt, first_pop, last_pop, stall_seen;
  logic [31:0] last_mask;
  logic        hold_pending = 1'b0;
  logic [15:0] held_dat;
  logic        held_last;

  task automatic push_word(input logic [15:0] d);
    logic lst;
    lst = (tb_beats == PL - 1);
    fifo_q.push_back(d);
    fifo_empty = 1'b0;
    sb.push_back({lst, d});
    tb_beats = lst ? 0 : tb_beats + 1;
  endtask

  task automatic push_fifo_only(input logic [15:0] d);
    fifo_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic flush_all();
    fifo_q.delete();
    fifo_empty = 1'b1;
    sb.delete();
    tb_beats = 0;
  endtask

  task automatic clear_stats();
    rd_cnt = 0; first_rd = -1; first_vld = -1; pop_cnt = 0;
    first_pop = -1; last_pop = -1; stall_seen = 0; last_mask = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) check("sb_timeout", sb.size(), 0);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(posedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 0);
    #1;
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // FIFO model: read request seen before the edge returns data after it.
  always @(negedge clk) rd_s = fifo_rd;
  always @(posedge clk) begin
    logic [15:0] w;
    if (rst_n && rd_s) begin
      if (fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        fifo_dout <= w;
        fifo_empty = (fifo_q.size() == 0);
      end else begin
        check("rd_on_empty", 1, 0);
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(m_valid), 1);
        check("hold_dat", 32'(m_data), 32'(held_dat));
        check("hold_last", 32'(m_last), 32'(held_last));
      end
      hold_pending = m_valid && !m_ready;
      held_dat  = m_data;
      held_last = m_last;
      if (dut.inflight && dut.occ == 2'd2 && !(m_valid && m_ready))
        check("capture_overflow", 1, 0);
      if (fifo_rd) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (m_valid && !m_ready) stall_seen++;
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (m_last) last_mask = last_mask | (32'd1 << pop_cnt);
        if (sb.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("beat_dat", 32'(m_data), 32'(e[15:0]));
          check("beat_last", 32'(m_last), 32'(e[16]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_cyc;
    int n;
    rst_n = 1'b1; en = 1'b0; m_ready = 1'b0;
    fifo_dout = 16'h0; fifo_empty = 1'b1;
    clear_stats();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_rd", 32'(fifo_rd), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    step();

    // Packets: last on beats 4, 8, then 12 after an idle gap.
    clear_stats();
    m_ready = 1'b1;
    for (int i = 1; i <= 10; i++) push_word(16'h0100 + 16'(i));
    en = 1'b1;
    wait_sb(100);
    check("pkt_last_mask10", last_mask, 32'h0000_0110);
    en = 1'b0;
    wait_idle(20);
    repeat (3) step();
    push_word(16'h010B);
    push_word(16'h010C);
    en = 1'b1;
    wait_sb(50);
    check("pkt_last_mask12", last_mask, 32'h0000_1110);
    en = 1'b0;
    wait_idle(20);

    // Streaming latency and throughput.
    clear_stats();
    for (int i = 1; i <= 5; i++) push_word(16'(i));
    step();
    en = 1'b1;
    en_cyc = cyc;
    wait_sb(50);
    check("strm_rd_latency", 32'(first_rd - en_cyc), 1);
    check("strm_vld_latency", 32'(first_vld - first_rd), 2);
    check("strm_beat_span", 32'(last_pop - first_pop), 4);
    check("strm_beats", 32'(pop_cnt), 5);
    check("strm_busy", 32'(busy), 1);
    step();
    check("strm_rd_cnt", 32'(rd_cnt), 5);
    en = 1'b0;
    wait_idle(20);

    // Backpressure: only two reads until the consumer accepts.
    clear_stats();
    m_ready = 1'b0;
    for (int i = 1; i <= 10; i++) push_word(16'(i));
    en = 1'b1;
    repeat (10) step();
    check("bp_rd_cnt", 32'(rd_cnt), 2);
    check("bp_valid", 32'(m_valid), 1);
    check("bp_data", 32'(m_data), 32'h0001);
    m_ready = 1'b1;
    wait_sb(100);
    check("bp_beat_span", 32'(last_pop - first_pop), 9);
    check("bp_rd_total", 32'(rd_cnt), 10);
    en = 1'b0;
    wait_idle(20);

    // Drain: EN drops with one word buffered and one in flight.
    clear_stats();
    push_word(16'h00D1);
    push_word(16'h00D2);
    en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(dut.inflight && dut.occ == 2'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_setup", 32'(dut.inflight && dut.occ == 2'd1), 1);
    en = 1'b0;
    step();
    push_fifo_only(16'h00E1);
    push_fifo_only(16'h00E2);
    wait_sb(30);
    @(negedge clk);
    check("drain_busy_hold", 32'(busy), 1);
    @(negedge clk);
    check("drain_busy_fall", 32'(busy), 0);
    check("drain_rd_cnt", 32'(rd_cnt), 2);
    check("drain_pops", 32'(pop_cnt), 2);
    step();
    flush_all();

    // Asynchronous reset mid-stream with a full buffer.
    clear_stats();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(16'h00A0 + 16'(i));
    en = 1'b1;
    n = 0;
    @(negedge clk);
    while (dut.occ != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_setup_occ", 32'(dut.occ), 2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_fifo_rd", 32'(fifo_rd), 0);
    check("arst_m_valid", 32'(m_valid), 0);
    check("arst_busy", 32'(busy), 0);
    step();
    en = 1'b0;
    m_ready = 1'b1;
    flush_all();
    step();
    rst_n = 1'b1;
    clear_stats();
    repeat (5) step();
    check("arst_no_stale", 32'(pop_cnt), 0);
    push_word(16'h00B1);
    push_word(16'h00B2);
    en = 1'b1;
    wait_sb(30);
    check("arst_fresh_pops", 32'(pop_cnt), 2);
    en = 1'b0;
    wait_idle(20);

`ifdef FIFO_RD_STATS_EN
    rst_n = 1'b0;
    flush_all();
    step();
    rst_n = 1'b1;
    clear_stats();
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_word(16'h00C0 + 16'(i));
    en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    step();
    m_ready = 1'b1;
    wait_sb(50);
    check("stat_stalls_seen", 32'(stall_seen), 3);
    check("stat_word_cnt", word_cnt, 6);
    check("stat_stall_cnt", stall_cnt, 3);
    force dut.word_cnt = 32'hFFFF_FFFF;
    step();
    release dut.word_cnt;
    push_word(16'h00CF);
    wait_sb(30);
    @(negedge clk);
    check("stat_word_sat", word_cnt, 32'hFFFF_FFFF);
    en = 1'b0;
    wait_idle(20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
